// File: rtl/program_loader_pkg.sv
// Shared constants for the program loader: FSM state encoding and word geometry.
package program_loader_pkg;

  localparam int WORD_BYTES = 4;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_LEN_LO = 3'd1;
  localparam state_t S_LEN_HI = 3'd2;
  localparam state_t S_DATA   = 3'd3;
  localparam state_t S_WRITE  = 3'd4;
  localparam state_t S_DONE   = 3'd5;
  localparam state_t S_ERROR  = 3'd6;

endpackage

// File: rtl/program_loader_if.sv
// Byte stream in and instruction-RAM write port out of the program loader.
interface program_loader_if;

  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        write_enable;
  logic [31:0] write_address;
  logic [31:0] write_data;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, write_enable, write_address, write_data
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, write_enable, write_address, write_data
  );

endinterface

// File: rtl/program_loader_word_assembler.sv
// Little-endian byte-to-word assembler; word_next shows the word including the byte being loaded.
module program_loader_word_assembler
  import program_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        full
);

  logic [1:0]  idx;
  logic [31:0] word_q;

  always_comb begin
    word_next = word_q;
    word_next[{idx, 3'b000} +: 8] = byte_in;
  end

  assign full = (idx == 2'(WORD_BYTES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx    <= 2'd0;
      word_q <= 32'd0;
    end else if (clear) begin
      idx <= 2'd0;
    end else if (load) begin
      word_q <= word_next;
      idx    <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed little-endian program image into instruction RAM.
//   state  | meaning
//   IDLE   | waiting for start after reset
//   LEN_LO | take low byte of word count
//   LEN_HI | take high byte; pick DONE, ERROR or DATA
//   DATA   | collect the four bytes of a word
//   WRITE  | one-cycle RAM write, no byte taken
//   DONE   | image loaded, done held
//   ERROR  | header exceeded MAX_WORDS, error held
module program_loader
  import program_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int unsigned MAX_WORDS    = 256
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  program_loader_if.slave   bus,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       word_count
);

  state_t      state;
  logic [15:0] length;
  logic [15:0] length_full;
  logic [15:0] count_next;
  logic [31:0] word_next;
  logic        word_full;
  logic        accept;
  logic        idle_like;

  assign bus.byte_ready   = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA);
  assign bus.write_enable = (state == S_WRITE);
  assign accept      = bus.byte_valid && bus.byte_ready;
  assign length_full = {bus.byte_data, length[7:0]};
  assign count_next  = word_count + 16'd1;
  assign idle_like   = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
  assign busy        = !idle_like;
  assign done        = (state == S_DONE);
  assign error       = (state == S_ERROR);

  program_loader_word_assembler u_assembler (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (state == S_LEN_HI),
    .load      (accept && (state == S_DATA)),
    .byte_in   (bus.byte_data),
    .word_next (word_next),
    .full      (word_full)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= S_IDLE;
      length            <= 16'd0;
      word_count        <= 16'd0;
      bus.write_address <= 32'd0;
      bus.write_data    <= 32'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            word_count <= 16'd0;
            state      <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            length[7:0] <= bus.byte_data;
            state       <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            length[15:8] <= bus.byte_data;
            if (length_full == 16'd0)
              state <= S_DONE;
            else if ({16'd0, length_full} > MAX_WORDS)
              state <= S_ERROR;
            else
              state <= S_DATA;
          end
        end
        S_DATA: begin
          // Latch address and word on the last byte so both are stable through WRITE.
          if (accept && word_full) begin
            bus.write_address <= BASE_ADDRESS + {14'd0, word_count, 2'b00};
            bus.write_data    <= word_next;
            state             <= S_WRITE;
          end
        end
        S_WRITE: begin
          word_count <= count_next;
          state      <= (count_next == length) ? S_DONE : S_DATA;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
